// File: rtl/fhdo_spi_pkg.sv
// Shared constants, state encoding and DAC command codes for the GPA-FHDO SPI master.
package fhdo_spi_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned DIV_WIDTH  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0] DAC0 = 8'h08;
    localparam logic [7:0] DAC1 = 8'h09;
    localparam logic [7:0] DAC2 = 8'h0A;
    localparam logic [7:0] DAC3 = 8'h0B;

endpackage

// File: rtl/fhdo_spi_master_if.sv
// Frame request / SPI pin bundle between the flocra gradient path and the FHDO master.
interface fhdo_spi_master_if;
    import fhdo_spi_pkg::*;

    logic [DIV_WIDTH-1:0]  spi_div_i;
    logic [FRAME_BITS-1:0] data_i;
    logic                  valid_i;
    logic                  busy_o;
    logic                  drop_o;
    logic                  fhdo_clk_o;
    logic                  fhdo_sdo_o;
    logic                  fhdo_ssn_o;
    logic                  fhdo_sdi_i;
    logic [DATA_BITS-1:0]  adc_value_o;
    logic                  adc_valid_o;

    modport master (
        input  spi_div_i, data_i, valid_i, fhdo_sdi_i,
        output busy_o, drop_o, fhdo_clk_o, fhdo_sdo_o, fhdo_ssn_o, adc_value_o, adc_valid_o
    );

    modport slave (
        output spi_div_i, data_i, valid_i, fhdo_sdi_i,
        input  busy_o, drop_o, fhdo_clk_o, fhdo_sdo_o, fhdo_ssn_o, adc_value_o, adc_valid_o
    );

endinterface

// File: rtl/fhdo_spi_clkgen.sv
// Half-period timer: phase_end marks the last cycle of each H-cycle phase, odd_phase
// is set during the second phase after a restart (the SCLK-low half in SHIFT).
module fhdo_spi_clkgen
    import fhdo_spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 restart,
    output logic                 phase_end,
    output logic                 odd_phase
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 odd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
            odd_q <= 1'b0;
        end else begin
            if (load) begin
                div_q <= div;
            end
            if (restart) begin
                cnt_q <= '0;
                odd_q <= 1'b0;
            end else if (phase_end) begin
                cnt_q <= '0;
                odd_q <= ~odd_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign phase_end = (cnt_q == div_q);
    assign odd_phase = odd_q;

endmodule

// File: rtl/fhdo_spi_master.sv
// SPI master for the GPA-FHDO gradient board (mode 1, 24-bit frames, MSB first).
// Define FHDO_SPI_READBACK_EN to build the SDI capture path and ADC readback outputs.
module fhdo_spi_master
    import fhdo_spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fhdo_spi_master_if.master bus
);

    state_e                state_q;
    logic [FRAME_BITS-2:0] tx_q;
    logic [4:0]            bit_cnt_q;
    logic                  busy_q;
    logic                  drop_q;
    logic                  sclk_q;
    logic                  sdo_q;
    logic                  ssn_q;

    logic accept;
    logic restart;
    logic phase_end;
    logic odd_phase;
    logic sample;
    logic shift_done;

    assign accept     = (state_q == StIdle) && bus.valid_i;
    assign sample     = (state_q == StShift) && phase_end && !odd_phase;
    assign shift_done = (state_q == StShift) && phase_end && odd_phase && (bit_cnt_q == 5'd0);

    // Timer restarts exactly on each state transition so every state starts at count 0.
    always_comb begin
        restart = 1'b0;
        unique case (state_q)
            StIdle:  restart = bus.valid_i;
            StSetup: restart = phase_end;
            StShift: restart = shift_done;
            StHold:  restart = phase_end;
            StGap:   restart = phase_end && odd_phase;
            default: restart = 1'b0;
        endcase
    end

    fhdo_spi_clkgen u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .div       (bus.spi_div_i),
        .restart   (restart),
        .phase_end (phase_end),
        .odd_phase (odd_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            ssn_q     <= 1'b1;
        end else begin
            drop_q <= bus.valid_i && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (bus.valid_i) begin
                        state_q <= StSetup;
                        tx_q    <= bus.data_i[FRAME_BITS-2:0];
                        sdo_q   <= bus.data_i[FRAME_BITS-1];
                        busy_q  <= 1'b1;
                        ssn_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                    end
                end
                StSetup: begin
                    if (phase_end) begin
                        state_q   <= StShift;
                        sclk_q    <= 1'b1;
                        bit_cnt_q <= 5'(FRAME_BITS - 1);
                    end
                end
                StShift: begin
                    if (phase_end && !odd_phase) begin
                        sclk_q <= 1'b0;
                    end else if (shift_done) begin
                        state_q <= StHold;
                    end else if (phase_end) begin
                        // Mode 1: next bit goes out together with the rising edge.
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        sclk_q    <= 1'b1;
                        sdo_q     <= tx_q[FRAME_BITS-2];
                        tx_q      <= {tx_q[FRAME_BITS-3:0], 1'b0};
                    end
                end
                StHold: begin
                    if (phase_end) begin
                        state_q <= StGap;
                        ssn_q   <= 1'b1;
                        sdo_q   <= 1'b0;
                    end
                end
                StGap: begin
                    if (phase_end && odd_phase) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.drop_o     = drop_q;
    assign bus.fhdo_clk_o = sclk_q;
    assign bus.fhdo_sdo_o = sdo_q;
    assign bus.fhdo_ssn_o = ssn_q;

`ifdef FHDO_SPI_READBACK_EN
    logic [FRAME_BITS-1:0] capture_q;
    logic [DATA_BITS-1:0]  adc_value_q;
    logic                  adc_valid_q;
    logic                  unused_capture_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            capture_q   <= '0;
            adc_value_q <= '0;
            adc_valid_q <= 1'b0;
        end else begin
            adc_valid_q <= shift_done;
            if (sample) begin
                capture_q <= {capture_q[FRAME_BITS-2:0], bus.fhdo_sdi_i};
            end
            if (shift_done) begin
                adc_value_q <= capture_q[DATA_BITS-1:0];
            end
        end
    end

    assign unused_capture_msb = capture_q[FRAME_BITS-1];
    assign bus.adc_value_o    = adc_value_q;
    assign bus.adc_valid_o    = adc_valid_q;
`else
    logic unused_readback;

    assign unused_readback = bus.fhdo_sdi_i ^ sample;
    assign bus.adc_value_o = '0;
    assign bus.adc_valid_o = 1'b0;
`endif

endmodule
